// File: rtl/mealy_pattern_detector_n.sv
// DEPTH-sample serial window compared against CHANNELS programmable masked patterns, Mealy outputs.
// Optional saturating per-channel hit counters are built when MEALY_HIT_COUNT_EN is defined.

module mealy_pattern_detector_n_chan #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             accept,
  input  logic             clear,
  input  logic             no_overlap,
  input  logic [DEPTH-1:0] w,
  input  logic [DEPTH-1:0] vpos,
  input  logic [DEPTH-1:0] pat,
  input  logic [DEPTH-1:0] msk,
  output logic             o,
  output logic [CNT_W-1:0] cnt
);
  localparam int BW = $clog2(DEPTH);

  logic [BW-1:0] blk;
  logic          match;

  // A cared position must be both inside the filled window and equal to the pattern.
  assign match = &(~msk | (vpos & ~(w ^ pat)));
  assign o     = reset_n & accept & match & (blk == '0);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)                 blk <= '0;
    else if (clear || !no_overlap) blk <= '0;
    else if (o)                   blk <= BW'(DEPTH-1);
    else if (accept && blk != '0) blk <= blk - 1'b1;
  end

`ifdef MEALY_HIT_COUNT_EN
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)               cnt <= '0;
    else if (clear)             cnt <= '0;
    else if (o && cnt != '1)    cnt <= cnt + 1'b1;
  end
`else
  assign cnt = '0;
`endif
endmodule

module mealy_pattern_detector_n #(
  parameter int DEPTH    = 4,
  parameter int CHANNELS = 2,
  parameter int CNT_W    = 8
) (
  input  logic                         clock,
  input  logic                         reset_n,
  input  logic                         i_valid,
  input  logic                         i,
  input  logic                         clear,
  input  logic                         no_overlap,
  input  logic [CHANNELS*DEPTH-1:0]    pattern,
  input  logic [CHANNELS*DEPTH-1:0]    mask,
  output logic [CHANNELS-1:0]          o,
  output logic [$clog2(DEPTH)-1:0]     fill,
  output logic [CHANNELS*CNT_W-1:0]    hit_count
);
  localparam int FW = $clog2(DEPTH);

  logic [DEPTH-2:0] hist;
  logic [DEPTH-1:0] w, vpos;
  logic             accept;

  assign accept = i_valid & ~clear;
  assign w      = {hist, i};

  always_comb begin
    vpos = '0;
    for (int k = 0; k < DEPTH; k++) vpos[k] = (k <= int'(fill));
  end

  // Shifting in w[DEPTH-2:0] places i at hist[0] and ages every older sample by one.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      hist <= '0;
      fill <= '0;
    end else if (clear) begin
      hist <= '0;
      fill <= '0;
    end else if (i_valid) begin
      hist <= w[DEPTH-2:0];
      if (fill != FW'(DEPTH-1)) fill <= fill + 1'b1;
    end
  end

  for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
    mealy_pattern_detector_n_chan #(.DEPTH(DEPTH), .CNT_W(CNT_W)) u_chan (
      .clock      (clock),
      .reset_n    (reset_n),
      .accept     (accept),
      .clear      (clear),
      .no_overlap (no_overlap),
      .w          (w),
      .vpos       (vpos),
      .pat        (pattern[c*DEPTH +: DEPTH]),
      .msk        (mask[c*DEPTH +: DEPTH]),
      .o          (o[c]),
      .cnt        (hit_count[c*CNT_W +: CNT_W])
    );
  end
endmodule

// File: tb/tb_mealy_pattern_detector_n.sv
// Directed bench for mealy_pattern_detector_n; a second instance with CNT_W=2 shares all inputs.
module tb_mealy_pattern_detector_n;
`ifdef MEALY_HIT_COUNT_EN
  localparam int EN = 1;
`else
  localparam int EN = 0;
`endif

  logic       clock = 0, reset_n = 0, i_valid = 0, i = 0, clear = 0, no_overlap = 0;
  logic [7:0] pattern = '0, mask = '0;
  logic [1:0] o, o2, fill, fill2;
  logic [15:0] hc;
  logic [3:0]  hc2;
  int total = 0, bad = 0;

  mealy_pattern_detector_n #(.DEPTH(4), .CHANNELS(2), .CNT_W(8)) dut (
    .clock(clock), .reset_n(reset_n), .i_valid(i_valid), .i(i), .clear(clear),
    .no_overlap(no_overlap), .pattern(pattern), .mask(mask), .o(o), .fill(fill),
    .hit_count(hc));

  mealy_pattern_detector_n #(.DEPTH(4), .CHANNELS(2), .CNT_W(2)) dut2 (
    .clock(clock), .reset_n(reset_n), .i_valid(i_valid), .i(i), .clear(clear),
    .no_overlap(no_overlap), .pattern(pattern), .mask(mask), .o(o2), .fill(fill2),
    .hit_count(hc2));

  always #5 clock = ~clock;

  function automatic int sat3(input int n);
    return (n > 3) ? 3 : n;
  endfunction

  task automatic drive(input logic v, input logic b, input logic c);
    @(negedge clock); i_valid = v; i = b; clear = c; #1;
  endtask

  task automatic do_reset();
    @(negedge clock); reset_n = 0; i_valid = 0; clear = 0; #2; reset_n = 1;
  endtask

  task automatic test_reset();
    pattern = '0; mask = '0; i_valid = 1; i = 1; #3;
    total++; if (o !== 2'b00) begin bad++; $display("FAIL reset_o: got %b want 00", o); end
    total++; if (fill !== 2'd0) begin bad++; $display("FAIL reset_fill: got %0d want 0", fill); end
    total++; if (hc !== 16'd0 || hc2 !== 4'd0) begin bad++; $display("FAIL reset_cnt: got %h/%h want 0", hc, hc2); end
    i_valid = 0; #2; reset_n = 1;
  endtask

  task automatic test_legacy();
    logic sb [17] = '{0,0,0,1,1,1,0,0,1,1,0,0,1,1,0,1,1};
    // s14 also closes a 0,0,1 run for ch1, so ch1 fires there too.
    logic [1:0] ex [17] = '{0,0,0,2,2,0,0,0,0,2,0,0,0,2,0,0,1};
    pattern = {4'b0001, 4'b1011}; mask = {4'b1101, 4'b1011}; no_overlap = 0;
    do_reset();
    for (int n = 0; n < 17; n++) begin
      drive(1, sb[n], 0);
      total++; if (o !== ex[n]) begin bad++; $display("FAIL legacy_o s%0d: got %b want %b", n+1, o, ex[n]); end
    end
    drive(0, 0, 0);
    total++; if (hc !== {8'(EN*4), 8'(EN*1)}) begin bad++; $display("FAIL legacy_cnt: got %h want %h", hc, {8'(EN*4), 8'(EN*1)}); end
    total++; if (hc2 !== {2'(EN*3), 2'(EN*1)}) begin bad++; $display("FAIL legacy_cnt2: got %h want %h", hc2, {2'(EN*3), 2'(EN*1)}); end
  endtask

  task automatic test_non_overlap();
    logic ex0 [6] = '{0,1,1,1,1,1};
    logic ex1 [6] = '{0,1,0,0,0,1};
    pattern = {4'b0000, 4'b0011}; mask = {4'b0001, 4'b0011};
    for (int m = 0; m < 2; m++) begin
      no_overlap = (m == 1);
      do_reset();
      for (int n = 0; n < 6; n++) begin
        drive(1, 1, 0);
        total++;
        if (o !== {1'b0, (m == 1) ? ex1[n] : ex0[n]}) begin
          bad++; $display("FAIL novl%0d_o s%0d: got %b want %b", m, n+1, o, {1'b0, (m == 1) ? ex1[n] : ex0[n]});
        end
      end
      drive(0, 0, 0);
      total++; if (hc[7:0] !== 8'(EN * ((m == 1) ? 2 : 5))) begin bad++; $display("FAIL novl%0d_cnt: got %0d want %0d", m, hc[7:0], EN * ((m == 1) ? 2 : 5)); end
      total++; if (hc2[1:0] !== 2'(EN * sat3((m == 1) ? 2 : 5))) begin bad++; $display("FAIL novl%0d_sat: got %0d want %0d", m, hc2[1:0], EN * sat3((m == 1) ? 2 : 5)); end
    end
    no_overlap = 0;
  endtask

  task automatic test_fill();
    logic [1:0] ef [5] = '{0,1,2,3,3};
    logic       eo [5] = '{0,0,0,1,1};
    pattern = {4'b0000, 4'b0000}; mask = {4'b0000, 4'b1111};
    do_reset();
    for (int n = 0; n < 5; n++) begin
      drive(1, 0, 0);
      total++; if (fill !== ef[n]) begin bad++; $display("FAIL fill s%0d: got %0d want %0d", n+1, fill, ef[n]); end
      total++; if (o !== {1'b1, eo[n]}) begin bad++; $display("FAIL fill_o s%0d: got %b want %b", n+1, o, {1'b1, eo[n]}); end
    end
  endtask

  task automatic test_idle();
    pattern = {4'b0000, 4'b1011}; mask = {4'b0000, 4'b1111};
    do_reset();
    drive(1, 1, 0);
    total++; if (o !== 2'b10) begin bad++; $display("FAIL idle_pre1: got %b want 10", o); end
    drive(1, 0, 0);
    total++; if (o !== 2'b10) begin bad++; $display("FAIL idle_pre2: got %b want 10", o); end
    for (int n = 0; n < 5; n++) begin
      drive(0, n[0], 0);
      total++; if (o !== 2'b00) begin bad++; $display("FAIL idle_o c%0d: got %b want 00", n, o); end
      total++; if (fill !== 2'd2) begin bad++; $display("FAIL idle_fill c%0d: got %0d want 2", n, fill); end
    end
    drive(1, 1, 0);
    total++; if (o !== 2'b10) begin bad++; $display("FAIL idle_post1: got %b want 10", o); end
    drive(1, 1, 0);
    total++; if (o !== 2'b11) begin bad++; $display("FAIL idle_post2: got %b want 11", o); end
  endtask

  task automatic test_clear_reset();
    drive(1, 1, 1);
    total++; if (o !== 2'b00) begin bad++; $display("FAIL clr_o: got %b want 00", o); end
    total++; if (hc !== {8'(EN*4), 8'(EN*1)}) begin bad++; $display("FAIL clr_precnt: got %h want %h", hc, {8'(EN*4), 8'(EN*1)}); end
    drive(1, 1, 0);
    total++; if (fill !== 2'd0) begin bad++; $display("FAIL clr_fill: got %0d want 0", fill); end
    total++; if (hc !== 16'd0) begin bad++; $display("FAIL clr_cnt: got %h want 0", hc); end
    total++; if (o !== 2'b10) begin bad++; $display("FAIL clr_o2: got %b want 10", o); end
    drive(1, 0, 0);
    total++; if (fill !== 2'd1) begin bad++; $display("FAIL clr_fill2: got %0d want 1", fill); end
    drive(1, 1, 0);
    reset_n = 0; #1;
    total++; if (o !== 2'b00) begin bad++; $display("FAIL arst_o: got %b want 00", o); end
    total++; if (fill !== 2'd0 || hc !== 16'd0) begin bad++; $display("FAIL arst_state: got fill=%0d cnt=%h want 0", fill, hc); end
    i_valid = 0; #1; reset_n = 1;
    drive(1, 1, 0);
    total++; if (fill !== 2'd0 || o !== 2'b10) begin bad++; $display("FAIL arst_after: got fill=%0d o=%b want 0/10", fill, o); end
  endtask

  initial begin
    test_reset();
    test_legacy();
    test_non_overlap();
    test_fill();
    test_idle();
    test_clear_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
